// File: rtl/run_event_counter.sv
// Counts rising edges of the run-detector flag, split by run type, as two
// 2-digit BCD counters with sticky overflow and four 7-segment digit drivers.
module run_event_counter #(
    parameter logic WRAP           = 1'b1,
    parameter logic SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       aclr,
    input  logic       z,
    input  logic       run_ones,
    input  logic       clr,
    output logic [7:0] cnt0,
    output logic [7:0] cnt1,
    output logic       ovf0,
    output logic       ovf1,
    output logic       evt,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3
);

    localparam int NUM_CNT = 2;
    localparam int NUM_DIG = 4;

    logic                          r_z_d;
    logic [NUM_CNT-1:0][7:0]       r_cnt;
    logic [NUM_CNT-1:0]            r_ovf;
    logic                          r_evt;

    logic                          w_event;
    logic                          w_sel;
    logic [NUM_CNT-1:0][7:0]       w_cnt_inc;
    logic [NUM_CNT-1:0]            w_ovf_hit;
    logic [NUM_DIG-1:0][3:0]       w_dig;
    logic [NUM_DIG-1:0][6:0]       w_seg;

    // {ovf_hit, next}; an out-of-range nibble resyncs the counter to 00
    function automatic logic [8:0] bcd_inc(input logic [7:0] v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9)
            return {1'b0, 8'h00};
        else if (v == 8'h99)
            return {1'b1, (WRAP ? 8'h00 : 8'h99)};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // active-high segments g..a; A-F blank
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h3F;
            4'd1:    return 7'h06;
            4'd2:    return 7'h5B;
            4'd3:    return 7'h4F;
            4'd4:    return 7'h66;
            4'd5:    return 7'h6D;
            4'd6:    return 7'h7D;
            4'd7:    return 7'h07;
            4'd8:    return 7'h7F;
            4'd9:    return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign w_event = z & ~r_z_d;
    assign w_sel   = run_ones;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        assign {w_ovf_hit[g], w_cnt_inc[g]} = bcd_inc(r_cnt[g]);
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_z_d <= 1'b0;
            r_cnt <= '0;
            r_ovf <= '0;
            r_evt <= 1'b0;
        end else begin
            r_z_d <= z;
            r_evt <= 1'b0;
            if (clr) begin
                r_cnt <= '0;
                r_ovf <= '0;
            end else if (w_event) begin
                r_evt        <= 1'b1;
                r_cnt[w_sel] <= w_cnt_inc[w_sel];
                if (w_ovf_hit[w_sel])
                    r_ovf[w_sel] <= 1'b1;
            end
        end
    end

    // digit order: cnt0 units, cnt0 tens, cnt1 units, cnt1 tens
    assign w_dig = {r_cnt[1], r_cnt[0]};

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_seg
        assign w_seg[g] = seg7(w_dig[g]) ^ {7{SEG_ACTIVE_LOW}};
    end

    assign cnt0 = r_cnt[0];
    assign cnt1 = r_cnt[1];
    assign ovf0 = r_ovf[0];
    assign ovf1 = r_ovf[1];
    assign evt  = r_evt;
    assign hex0 = w_seg[0];
    assign hex1 = w_seg[1];
    assign hex2 = w_seg[2];
    assign hex3 = w_seg[3];

endmodule

// File: tb/tb_run_event_counter.sv
// Bench for run_event_counter: table vectors plus model-driven pulse trains,
// with a wrapping/active-low DUT and a saturating/active-high DUT side by side.
module tb_run_event_counter;

    logic       clk, aclr, z, run_ones, clr;
    logic [7:0] cnt0, cnt1, cnt0_s, cnt1_s;
    logic       ovf0, ovf1, evt, ovf0_s, ovf1_s, evt_s;
    logic [6:0] hex0, hex1, hex2, hex3, hex0_s, hex1_s, hex2_s, hex3_s;

    run_event_counter #(.WRAP(1'b1), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .aclr(aclr), .z(z), .run_ones(run_ones), .clr(clr),
        .cnt0(cnt0), .cnt1(cnt1), .ovf0(ovf0), .ovf1(ovf1), .evt(evt),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3));

    run_event_counter #(.WRAP(1'b0), .SEG_ACTIVE_LOW(1'b0)) dut_s (
        .clk(clk), .aclr(aclr), .z(z), .run_ones(run_ones), .clr(clr),
        .cnt0(cnt0_s), .cnt1(cnt1_s), .ovf0(ovf0_s), .ovf1(ovf1_s), .evt(evt_s),
        .hex0(hex0_s), .hex1(hex1_s), .hex2(hex2_s), .hex3(hex3_s));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       z, ro, clr;
        logic [7:0] c0, c1;
        logic       o0, o1, ev;
    } vec_t;

    typedef struct {
        logic [7:0] c0, c1, c1s;
        logic       o0, o1, o1s, ev;
    } exp_t;

    exp_t q[$];
    vec_t tbl[10];
    int   total = 0;
    int   bad   = 0;

    // model state, kept in plain decimal
    int   md0 = 0, md1 = 0, md1s = 0;
    logic mo0 = 0, mo1 = 0, mo1s = 0, mev = 0, mzd = 0;

    function automatic logic [7:0] to_bcd(input int d);
        logic [3:0] t, u;
        t = 4'(d / 10);
        u = 4'(d % 10);
        return {t, u};
    endfunction

    // active-low segment patterns, g..a
    function automatic logic [6:0] seg_lo(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        md0 = 0; md1 = 0; md1s = 0;
        mo0 = 0; mo1 = 0; mo1s = 0; mev = 0; mzd = 0;
    endtask

    task automatic model_step(input logic iz, input logic iro, input logic iclr, output exp_t e);
        if (iclr) begin
            md0 = 0; md1 = 0; md1s = 0;
            mo0 = 0; mo1 = 0; mo1s = 0; mev = 0;
        end else if (iz && !mzd) begin
            mev = 1;
            if (iro) begin
                if (md1 == 99) begin md1 = 0; mo1 = 1; end
                else md1++;
                if (md1s == 99) mo1s = 1;
                else md1s++;
            end else begin
                if (md0 == 99) begin md0 = 0; mo0 = 1; end
                else md0++;
            end
        end else begin
            mev = 0;
        end
        mzd = iz;
        e.c0 = to_bcd(md0); e.c1 = to_bcd(md1); e.c1s = to_bcd(md1s);
        e.o0 = mo0; e.o1 = mo1; e.o1s = mo1s; e.ev = mev;
    endtask

    task automatic check_pop();
        exp_t e;
        if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: got empty queue want entry");
            return;
        end
        e = q.pop_front();
        chk("cnt0", cnt0, e.c0);
        chk("cnt1", cnt1, e.c1);
        chk("ovf0", {7'd0, ovf0}, {7'd0, e.o0});
        chk("ovf1", {7'd0, ovf1}, {7'd0, e.o1});
        chk("evt",  {7'd0, evt},  {7'd0, e.ev});
        chk("hex0", {1'b0, hex0}, {1'b0, seg_lo(e.c0[3:0])});
        chk("hex1", {1'b0, hex1}, {1'b0, seg_lo(e.c0[7:4])});
        chk("hex2", {1'b0, hex2}, {1'b0, seg_lo(e.c1[3:0])});
        chk("hex3", {1'b0, hex3}, {1'b0, seg_lo(e.c1[7:4])});
        chk("sat_cnt1", cnt1_s, e.c1s);
        chk("sat_ovf1", {7'd0, ovf1_s}, {7'd0, e.o1s});
        chk("sat_hex2", {1'b0, hex2_s}, {1'b0, ~seg_lo(e.c1s[3:0])});
    endtask

    task automatic step(input logic iz, input logic iro, input logic iclr);
        exp_t e;
        @(negedge clk);
        z = iz; run_ones = iro; clr = iclr;
        model_step(iz, iro, iclr, e);
        q.push_back(e);
        @(posedge clk); #1;
        check_pop();
    endtask

    task automatic tstep(input vec_t v);
        exp_t e, m;
        @(negedge clk);
        z = v.z; run_ones = v.ro; clr = v.clr;
        model_step(v.z, v.ro, v.clr, m);
        e.c0 = v.c0; e.c1 = v.c1; e.c1s = v.c1;
        e.o0 = v.o0; e.o1 = v.o1; e.o1s = v.o1; e.ev = v.ev;
        q.push_back(e);
        @(posedge clk); #1;
        check_pop();
    endtask

    task automatic pulse(input logic iro);
        step(1'b1, iro, 1'b0);
        step(1'b0, iro, 1'b0);
    endtask

    initial begin
        exp_t e;
        // idle, then one zero-run held 4 cycles (run_ones wiggles mid-run)
        for (int i = 0; i < 5; i++) tbl[i] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0};

        aclr = 1'b1; z = 1'b0; run_ones = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt0", cnt0, 8'h00);
        chk("rst_cnt1", cnt1, 8'h00);
        chk("rst_flags", {5'd0, ovf0, ovf1, evt}, 8'h00);
        chk("rst_hex0", {1'b0, hex0}, 8'h40);
        chk("rst_hex3", {1'b0, hex3}, 8'h40);
        @(negedge clk);
        aclr = 1'b0;
        model_reset();

        for (int i = 0; i < 10; i++) tstep(tbl[i]);

        // 12 one-runs and 3 zero-runs from a cleared state
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 12; i++) pulse(1'b1);
        for (int i = 0; i < 3; i++) pulse(1'b0);
        chk("mix_cnt1", cnt1, 8'h12);
        chk("mix_cnt0", cnt0, 8'h03);
        chk("mix_hex2", {1'b0, hex2}, 8'h24);
        chk("mix_hex3", {1'b0, hex3}, 8'h79);
        chk("mix_hex1", {1'b0, hex1}, 8'h40);

        // 100 one-runs: wrap vs saturate at 99
        step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 99; i++) pulse(1'b1);
        chk("at99_cnt1", cnt1, 8'h99);
        chk("at99_ovf1", {7'd0, ovf1}, 8'h00);
        pulse(1'b1);
        chk("wrap_cnt1", cnt1, 8'h00);
        chk("wrap_ovf1", {7'd0, ovf1}, 8'h01);
        chk("sat_cnt1_100", cnt1_s, 8'h99);
        chk("sat_ovf1_100", {7'd0, ovf1_s}, 8'h01);
        for (int i = 0; i < 3; i++) pulse(1'b1);
        chk("wrap_ovf1_sticky", {7'd0, ovf1}, 8'h01);
        chk("wrap_cnt1_after", cnt1, 8'h03);

        // clr on the same edge as a z rise, z held afterwards
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("clr_cnt1", cnt1, 8'h00);

        // async clear mid-cycle while z is high
        for (int i = 0; i < 5; i++) pulse(1'b0);
        chk("pre_aclr_cnt0", cnt0, 8'h05);
        @(negedge clk);
        z = 1'b1; run_ones = 1'b0; clr = 1'b0;
        #1 aclr = 1'b1;
        #1;
        chk("aclr_cnt0", cnt0, 8'h00);
        chk("aclr_hex0", {1'b0, hex0}, 8'h40);
        #1 aclr = 1'b0;
        model_reset();
        model_step(1'b1, 1'b0, 1'b0, e);
        q.push_back(e);
        @(posedge clk); #1;
        check_pop();
        chk("post_aclr_cnt0", cnt0, 8'h01);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
